game_sequencer: RTL and testbench

// Top-level game-flow controller for the brick-smashing ball-and-paddle game. Sequences attract,

---
 rtl/game_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level game-flow controller for the brick-smashing ball-and-paddle game.
//
// The controller steps through the game phases on frame ticks taken from the
// VGA vsync:
//   ATTRACT -> SERVE -> PLAY -> LOST / LEVEL -> ... -> GAMEOVER -> ATTRACT
//
// It also does the following:
//   - gates ball motion through ball_hold;
//   - requests score/lives and brick-array clears;
//   - emits life-decrement pulses to player_stats.
//
// Ports
//   clk          in   1  pixel clock, all state on posedge
//   reset        in   1  asynchronous assert, active-low reset
//   vsync        in   1  VGA vsync (clk domain), rising edge = frame tick
//   start_n      in   1  start button, active low, asynchronous
//   ball_y       in   9  current ball Y position
//   brick_hit    in   1  one-clk pulse per destroyed brick
//   lives        in   4  lives remaining (from player_stats)
//   state        out  3  0 ATTRACT, 1 SERVE, 2 PLAY, 3 LOST, 4 LEVEL, 5 GAMEOVER
//   ball_hold    out  1  ball frozen at serve position (all states but PLAY)
//   new_game     out  1  one-clk pulse, reset score and lives
//   clear_bricks out  1  one-clk pulse, restore all bricks
//   declives     out  1  one-clk pulse, decrement lives
//   level        out  4  current level, saturates at 15
//   bricks_left  out  8  bricks remaining this level
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 90,
  parameter int LEVEL_FRAMES = 120,
  parameter int OVER_FRAMES  = 180,
  parameter int NUM_BRICKS   = 128,
  parameter int BALL_LOST_Y  = 232
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start_n,
  input  logic [8:0] ball_y,
  input  logic       brick_hit,
  input  logic [3:0] lives,
  output logic [2:0] state,
  output logic       ball_hold,
  output logic       new_game,
  output logic       clear_bricks,
  output logic       declives,
  output logic [3:0] level,
  output logic [7:0] bricks_left
);

  typedef enum logic [2:0] {
    S_ATTRACT  = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_LOST     = 3'd3,
    S_LEVEL    = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_LD    = 8'(SERVE_FRAMES);
  localparam logic [7:0] LOST_LD     = 8'(LOST_FRAMES);
  localparam logic [7:0] LEVEL_LD    = 8'(LEVEL_FRAMES);
  localparam logic [7:0] OVER_LD     = 8'(OVER_FRAMES);
  localparam logic [7:0] BRICKS_INIT = 8'(NUM_BRICKS);
  localparam logic [8:0] LOST_Y      = 9'(BALL_LOST_Y);

  state_t     st;
  logic [7:0] timer;

  // Frame tick and start-button synchroniser / edge detectors
  logic vsync_q;
  logic start_s1;
  logic start_s2;
  logic start_s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q  <= 1'b0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      start_s1 <= start_n;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
    end
  end

  logic       tick;
  logic       start_pulse;
  logic       timer_done;
  logic       ball_lost;
  logic [7:0] bricks_after_hit;

  assign tick        = vsync & ~vsync_q;
  // Falling edge of the synchronised button: it was high, it is now low.
  assign start_pulse = start_s3 & ~start_s2;
  // The phase ends on the tick that takes the timer from 1 to 0. A zero
  // timer is also treated as expired, so a timed phase can never stall.
  assign timer_done  = tick && (timer <= 8'd1);
  assign ball_lost   = tick && (ball_y >= LOST_Y);
  // Floor at zero so a stray hit can never wrap the count.
  assign bricks_after_hit = (brick_hit && (bricks_left != 8'd0)) ?
                            bricks_left - 8'd1 : bricks_left;

  // Game-flow FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= S_ATTRACT;
      timer        <= 8'd0;
      ball_hold    <= 1'b1;
      new_game     <= 1'b0;
      clear_bricks <= 1'b0;
      declives     <= 1'b0;
      level        <= 4'd0;
      bricks_left  <= BRICKS_INIT;
    end else begin
      // Pulses default low. No transition can fire twice in a row, so every
      // pulse is exactly one clock wide.
      new_game     <= 1'b0;
      clear_bricks <= 1'b0;
      declives     <= 1'b0;

      // Free-running frame countdown. A state entry below reloads the timer
      // and, as the later assignment, takes precedence over the decrement.
      if (tick && (timer != 8'd0)) begin
        timer <= timer - 8'd1;
      end

      case (st)
        S_ATTRACT: begin
          level       <= 4'd0;
          bricks_left <= BRICKS_INIT;
          ball_hold   <= 1'b1;
          if (start_pulse) begin
            st           <= S_SERVE;
            timer        <= SERVE_LD;
            new_game     <= 1'b1;
            clear_bricks <= 1'b1;
          end
        end

        S_SERVE: begin
          if (timer_done) begin
            st        <= S_PLAY;
            ball_hold <= 1'b0;
            timer     <= 8'd0;
          end
        end

        S_PLAY: begin
          bricks_left <= bricks_after_hit;
          // Clearing the level wins over a simultaneous ball loss, so the
          // player is not charged a life for the frame that finished the level.
          if (bricks_after_hit == 8'd0) begin
            st        <= S_LEVEL;
            ball_hold <= 1'b1;
            timer     <= LEVEL_LD;
          end else if (ball_lost) begin
            st        <= S_LOST;
            ball_hold <= 1'b1;
            timer     <= LOST_LD;
            declives  <= 1'b1;
          end
        end

        S_LOST: begin
          // lives already reflects the declives pulse issued on entry.
          if (timer_done) begin
            if (lives == 4'd0) begin
              st    <= S_GAMEOVER;
              timer <= OVER_LD;
            end else begin
              st    <= S_SERVE;
              timer <= SERVE_LD;
            end
          end
        end

        S_LEVEL: begin
          if (timer_done) begin
            st           <= S_SERVE;
            timer        <= SERVE_LD;
            level        <= (level == 4'd15) ? level : level + 4'd1;
            bricks_left  <= BRICKS_INIT;
            clear_bricks <= 1'b1;
          end
        end

        S_GAMEOVER: begin
          if (timer_done) begin
            st    <= S_ATTRACT;
            timer <= 8'd0;
          end
        end

        default: begin
          // Encodings 6 and 7 are not reachable. Recover to the idle screen.
          st        <= S_ATTRACT;
          ball_hold <= 1'b1;
          timer     <= 8'd0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Directed, self-checking bench for game_sequencer with the default parameters.
// Each task drives one scenario and checks the outputs against hand-computed
// values.
//
// Timing conventions:
//   - Inputs change and outputs are sampled 1 time unit after each rising clock
//     edge.
//   - A negedge monitor counts the output pulses.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       start_n = 1'b1;
  logic [8:0] ball_y = 9'd100;
  logic       brick_hit = 1'b0;
  logic [3:0] lives = 4'd3;
  logic [2:0] state;
  logic       ball_hold;
  logic       new_game;
  logic       clear_bricks;
  logic       declives;
  logic [3:0] level;
  logic [7:0] bricks_left;

  int pass_cnt = 0;
  int total_cnt = 0;

  game_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .start_n      (start_n),
    .ball_y       (ball_y),
    .brick_hit    (brick_hit),
    .lives        (lives),
    .state        (state),
    .ball_hold    (ball_hold),
    .new_game     (new_game),
    .clear_bricks (clear_bricks),
    .declives     (declives),
    .level        (level),
    .bricks_left  (bricks_left)
  );

  always #5 clk = ~clk;

  // Pulse counters and back-to-back detector
  int   ng_cnt = 0;
  int   cb_cnt = 0;
  int   dl_cnt = 0;
  int   consec = 0;
  logic ng_q = 1'b0;
  logic cb_q = 1'b0;
  logic dl_q = 1'b0;

  always @(negedge clk) begin
    if (new_game === 1'b1)     ng_cnt++;
    if (clear_bricks === 1'b1) cb_cnt++;
    if (declives === 1'b1)     dl_cnt++;
    if ((new_game === 1'b1 && ng_q === 1'b1) ||
        (clear_bricks === 1'b1 && cb_q === 1'b1) ||
        (declives === 1'b1 && dl_q === 1'b1)) consec++;
    ng_q = new_game;
    cb_q = clear_bricks;
    dl_q = declives;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vsync = 1'b1;
      clk1();
      vsync = 1'b0;
      clk1();
    end
  endtask

  task automatic hits(input int n);
    repeat (n) begin
      brick_hit = 1'b1;
      clk1();
      brick_hit = 1'b0;
      clk1();
    end
  endtask

  task automatic press_start();
    start_n = 1'b0;
    repeat (4) clk1();
    start_n = 1'b1;
    repeat (4) clk1();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) clk1();
    total_cnt++;
    if (state !== 3'd0) $display("FAIL reset_hold_state: got %0d want 0", state); else pass_cnt++;
    reset = 1'b1;
    repeat (5) clk1();
    total_cnt++;
    if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
    total_cnt++;
    if (ball_hold !== 1'b1) $display("FAIL reset_ball_hold: got %b want 1", ball_hold); else pass_cnt++;
    total_cnt++;
    if (bricks_left !== 8'd128) $display("FAIL reset_bricks: got %0d want 128", bricks_left); else pass_cnt++;
    total_cnt++;
    if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
    total_cnt++;
    if ((ng_cnt + cb_cnt + dl_cnt) !== 0)
      $display("FAIL reset_pulses: got %0d want 0", ng_cnt + cb_cnt + dl_cnt);
    else pass_cnt++;
  endtask

  task automatic test_start();
    int ng0, cb0;
    ng0 = ng_cnt;
    cb0 = cb_cnt;
    press_start();
    total_cnt++;
    if (state !== 3'd1) $display("FAIL start_state: got %0d want 1", state); else pass_cnt++;
    total_cnt++;
    if (ng_cnt - ng0 !== 1) $display("FAIL start_new_game: got %0d want 1", ng_cnt - ng0); else pass_cnt++;
    total_cnt++;
    if (cb_cnt - cb0 !== 1) $display("FAIL start_clear: got %0d want 1", cb_cnt - cb0); else pass_cnt++;
    frames(59);
    total_cnt++;
    if (state !== 3'd1) $display("FAIL serve_59: got %0d want 1", state); else pass_cnt++;
    total_cnt++;
    if (ball_hold !== 1'b1) $display("FAIL serve_hold: got %b want 1", ball_hold); else pass_cnt++;
    frames(1);
    total_cnt++;
    if (state !== 3'd2) $display("FAIL serve_60: got %0d want 2", state); else pass_cnt++;
    total_cnt++;
    if (ball_hold !== 1'b0) $display("FAIL play_hold: got %b want 0", ball_hold); else pass_cnt++;
  endtask

  task automatic test_ball_lost();
    int dl0, ng0;
    lives = 4'd2;
    ball_y = 9'd231;
    frames(1);
    total_cnt++;
    if (state !== 3'd2) $display("FAIL lost_y231: got %0d want 2", state); else pass_cnt++;
    dl0 = dl_cnt;
    ball_y = 9'd240;
    frames(1);
    ball_y = 9'd100;
    total_cnt++;
    if (state !== 3'd3) $display("FAIL lost_state: got %0d want 3", state); else pass_cnt++;
    total_cnt++;
    if (dl_cnt - dl0 !== 1) $display("FAIL lost_declives: got %0d want 1", dl_cnt - dl0); else pass_cnt++;
    total_cnt++;
    if (ball_hold !== 1'b1) $display("FAIL lost_hold: got %b want 1", ball_hold); else pass_cnt++;
    frames(89);
    total_cnt++;
    if (state !== 3'd3) $display("FAIL lost_89: got %0d want 3", state); else pass_cnt++;
    frames(1);
    total_cnt++;
    if (state !== 3'd1) $display("FAIL lost_to_serve: got %0d want 1", state); else pass_cnt++;
    frames(60);
    total_cnt++;
    if (state !== 3'd2) $display("FAIL reserve_play: got %0d want 2", state); else pass_cnt++;
    lives = 4'd0;
    ball_y = 9'd232;
    frames(1);
    ball_y = 9'd100;
    total_cnt++;
    if (state !== 3'd3) $display("FAIL lost_y232: got %0d want 3", state); else pass_cnt++;
    frames(90);
    total_cnt++;
    if (state !== 3'd5) $display("FAIL gameover: got %0d want 5", state); else pass_cnt++;
    ng0 = ng_cnt;
    press_start();
    total_cnt++;
    if (state !== 3'd5) $display("FAIL over_start_ignored: got %0d want 5", state); else pass_cnt++;
    total_cnt++;
    if (ng_cnt - ng0 !== 0) $display("FAIL over_no_new_game: got %0d want 0", ng_cnt - ng0); else pass_cnt++;
    frames(179);
    total_cnt++;
    if (state !== 3'd5) $display("FAIL over_179: got %0d want 5", state); else pass_cnt++;
    frames(1);
    total_cnt++;
    if (state !== 3'd0) $display("FAIL over_to_attract: got %0d want 0", state); else pass_cnt++;
    lives = 4'd3;
  endtask

  task automatic test_level_clear();
    int cb0;
    press_start();
    frames(60);
    total_cnt++;
    if (state !== 3'd2) $display("FAIL lvl_play: got %0d want 2", state); else pass_cnt++;
    hits(127);
    total_cnt++;
    if (bricks_left !== 8'd1) $display("FAIL lvl_bricks_1: got %0d want 1", bricks_left); else pass_cnt++;
    total_cnt++;
    if (state !== 3'd2) $display("FAIL lvl_still_play: got %0d want 2", state); else pass_cnt++;
    hits(1);
    total_cnt++;
    if (bricks_left !== 8'd0) $display("FAIL lvl_bricks_0: got %0d want 0", bricks_left); else pass_cnt++;
    total_cnt++;
    if (state !== 3'd4) $display("FAIL lvl_state: got %0d want 4", state); else pass_cnt++;
    cb0 = cb_cnt;
    frames(119);
    total_cnt++;
    if (state !== 3'd4) $display("FAIL lvl_119: got %0d want 4", state); else pass_cnt++;
    frames(1);
    total_cnt++;
    if (state !== 3'd1) $display("FAIL lvl_to_serve: got %0d want 1", state); else pass_cnt++;
    total_cnt++;
    if (level !== 4'd1) $display("FAIL lvl_level: got %0d want 1", level); else pass_cnt++;
    total_cnt++;
    if (bricks_left !== 8'd128) $display("FAIL lvl_refill: got %0d want 128", bricks_left); else pass_cnt++;
    total_cnt++;
    if (cb_cnt - cb0 !== 1) $display("FAIL lvl_clear: got %0d want 1", cb_cnt - cb0); else pass_cnt++;
  endtask

  task automatic test_hit_and_loss();
    int dl0, ng0;
    hits(3);
    total_cnt++;
    if (bricks_left !== 8'd128) $display("FAIL serve_hit_ignored: got %0d want 128", bricks_left); else pass_cnt++;
    ng0 = ng_cnt;
    press_start();
    total_cnt++;
    if (state !== 3'd1) $display("FAIL serve_start_ignored: got %0d want 1", state); else pass_cnt++;
    total_cnt++;
    if (ng_cnt - ng0 !== 0) $display("FAIL serve_no_new_game: got %0d want 0", ng_cnt - ng0); else pass_cnt++;
    frames(60);
    hits(127);
    dl0 = dl_cnt;
    brick_hit = 1'b1;
    vsync = 1'b1;
    ball_y = 9'd240;
    clk1();
    brick_hit = 1'b0;
    vsync = 1'b0;
    clk1();
    ball_y = 9'd100;
    total_cnt++;
    if (state !== 3'd4) $display("FAIL tie_state: got %0d want 4", state); else pass_cnt++;
    total_cnt++;
    if (dl_cnt - dl0 !== 0) $display("FAIL tie_declives: got %0d want 0", dl_cnt - dl0); else pass_cnt++;
  endtask

  task automatic test_reset_midgame();
    int dl0, cb0;
    frames(120);
    frames(60);
    hits(5);
    total_cnt++;
    if (bricks_left !== 8'd123) $display("FAIL mid_bricks: got %0d want 123", bricks_left); else pass_cnt++;
    dl0 = dl_cnt;
    cb0 = cb_cnt;
    ball_y = 9'd240;
    vsync = 1'b1;
    #1 reset = 1'b0;
    #1;
    total_cnt++;
    if (state !== 3'd0) $display("FAIL mid_reset_async: got %0d want 0", state); else pass_cnt++;
    total_cnt++;
    if (level !== 4'd0) $display("FAIL mid_reset_level: got %0d want 0", level); else pass_cnt++;
    clk1();
    vsync = 1'b0;
    clk1();
    reset = 1'b1;
    ball_y = 9'd100;
    repeat (3) clk1();
    total_cnt++;
    if ((dl_cnt - dl0) + (cb_cnt - cb0) !== 0)
      $display("FAIL mid_reset_pulses: got %0d want 0", (dl_cnt - dl0) + (cb_cnt - cb0));
    else pass_cnt++;
    total_cnt++;
    if (bricks_left !== 8'd128) $display("FAIL mid_reset_bricks: got %0d want 128", bricks_left); else pass_cnt++;
  endtask

  task automatic test_level_saturate();
    press_start();
    for (int i = 0; i < 16; i++) begin
      frames(60);
      hits(128);
      frames(120);
    end
    total_cnt++;
    if (level !== 4'd15) $display("FAIL level_saturate: got %0d want 15", level); else pass_cnt++;
    total_cnt++;
    if (state !== 3'd1) $display("FAIL level_sat_state: got %0d want 1", state); else pass_cnt++;
  endtask

  task automatic test_pulse_shape();
    total_cnt++;
    if (consec !== 0) $display("FAIL pulse_back_to_back: got %0d want 0", consec); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_ball_lost();
    test_level_clear();
    test_hit_and_loss();
    test_reset_midgame();
    test_level_saturate();
    test_pulse_shape();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
